micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//   Microprogram sequencer that reads the control-unit microcode ROM.
//   It drives the ROM address (micro-PC) and receives the combinational
//   ROM control word back.
//   From that word's sequencing field it picks the next micro-address:
//   increment, jump, branch on Z, opcode dispatch, call/return or halt.
//   It forwards the word to the datapath as the active control signals.
// PARAMETERS
//   ADDR_W     5   micro-address width (ROM depth = 2**ADDR_W)
//   CW_W       37  control word width
//   FETCH_ADDR 0   micro-address of FETCH1; start/restart target
//   SEQ_LSB    5   lsb of 3-bit sequencing field cw_in[SEQ_LSB+2:SEQ_LSB]
// PORTS
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       leave IDLE/HALT, begin at FETCH_ADDR
//   stall      in   1       hold micro-PC this cycle (memory/bus wait)
//   z_flag     in   1       ALU zero flag, sampled for BRZ/BRNZ
//   opcode     in   ADDR_W  dispatch target from instruction register
//   cw_in      in   CW_W    ROM data for rom_addr (combinational ROM)
//   rom_addr   out  ADDR_W  ROM address = micro-PC register
//   ctrl_out   out  CW_W    control word to datapath
//   ctrl_valid out  1       ctrl_out is live this cycle
//   halted     out  1       state == HALT
// BEHAVIOUR
//   Address fields: target = cw_in[ADDR_W-1:0]; op = cw_in[SEQ_LSB+2:SEQ_LSB].
//   Reset (async, rst_n=0):
//     state=IDLE, upc=FETCH_ADDR, ret=FETCH_ADDR.
//     ctrl_out=0, ctrl_valid=0, halted=0.
//   States:
//     IDLE -> RUN on start.
//     RUN  -> HALT on executed op HALT.
//     HALT -> RUN on start (upc<=FETCH_ADDR).
//   Output gating (combinational):
//     ctrl_valid = (state==RUN) && !stall.
//     ctrl_out   = ctrl_valid ? cw_in : 0.
//   Executed = ctrl_valid cycle. upc and ret change only on executed cycles
//   or on start. One micro-instruction per clock; zero-cycle ROM latency.
//   Next upc on an executed cycle (all +1 wrap mod 2**ADDR_W):
//     000 NEXT    upc+1
//     001 JUMP    target
//     010 BRZ     z_flag ? target : upc+1
//     011 BRNZ    !z_flag ? target : upc+1
//     100 DISP    opcode
//     101 CALL    ret<=upc+1; upc<=target (1-deep; nested CALL overwrites ret)
//     110 RET     ret (RET without CALL goes to FETCH_ADDR)
//     111 HALT    upc held; the HALT word itself is output once
//   Boundaries:
//     - stall in RUN: upc/ret held, ctrl_out=0; the same word is re-executed
//       after the stall.
//     - start while RUN: ignored.
//     - start and stall together in IDLE/HALT: RUN entered; the first word is
//       held until stall drops.
//     - z_flag/opcode sampled only on executed cycles.
//     - upc = 2**ADDR_W-1 with NEXT: wraps to 0.
//     - rst_n low mid-program: immediate return to reset values,
//       independent of clk.
// TESTING
//   1. Reset then start; ROM[0]=NEXT, ROM[1]=JUMP 5
//      -> rom_addr 0,1,5 on successive clocks; ctrl_out=cw_in each cycle.
//   2. ROM[10]=BRNZ 13; z=0 -> upc 13. Repeat with z=1 -> upc 11.
//      BRZ with the same data gives the opposite result.
//   3. ROM[0]=DISP, opcode=5'd20 -> rom_addr=20 next cycle.
//      ROM[31]=NEXT -> wraps to 0.
//   4. CALL 23 at upc 4 -> upc=23, ret=5. RET at 23 -> upc=5.
//      RET straight after reset -> upc=FETCH_ADDR.
//   5. stall high 3 cycles at upc 20
//      -> rom_addr stays 20, ctrl_valid=0, ctrl_out=0. Resumes 20 -> next.
//   6. HALT at upc 26 -> word out once, halted=1, ctrl_valid=0 thereafter.
//      start -> rom_addr=0. Async rst_n pulse mid-run -> all outputs 0 at once.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the micro-PC, walks the microcode ROM and
// forwards the combinational control word to the datapath while running.
module micro_sequencer #(
   parameter int ADDR_W     = 5,
   parameter int CW_W       = 37,
   parameter int FETCH_ADDR = 0,
   parameter int SEQ_LSB    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stall,
   input  logic              z_flag,
   input  logic [ADDR_W-1:0] opcode,
   input  logic [CW_W-1:0]   cw_in,
   output logic [ADDR_W-1:0] rom_addr,
   output logic [CW_W-1:0]   ctrl_out,
   output logic              ctrl_valid,
   output logic              halted
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      OP_NEXT = 3'd0,
      OP_JUMP = 3'd1,
      OP_BRZ  = 3'd2,
      OP_BRNZ = 3'd3,
      OP_DISP = 3'd4,
      OP_CALL = 3'd5,
      OP_RET  = 3'd6,
      OP_HALT = 3'd7
   } seq_op_t;

   localparam logic [ADDR_W-1:0] FETCH = ADDR_W'(FETCH_ADDR);

   state_t            state;
   logic [ADDR_W-1:0] upc;
   logic [ADDR_W-1:0] ret;
   logic [ADDR_W-1:0] upc_inc;
   logic [ADDR_W-1:0] target;
   seq_op_t           op;

   assign upc_inc    = upc + ADDR_W'(1);
   assign target     = cw_in[ADDR_W-1:0];
   assign op         = seq_op_t'(cw_in[SEQ_LSB +: 3]);

   // A stalled RUN cycle does not execute, so the datapath sees an all-zero word.
   assign ctrl_valid = (state == RUN) && !stall;
   assign ctrl_out   = ctrl_valid ? cw_in : '0;
   assign rom_addr   = upc;
   assign halted     = (state == HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         upc   <= FETCH;
         ret   <= FETCH;
      end else begin
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  state <= RUN;
                  upc   <= FETCH;
               end
            end
            RUN: begin
               if (!stall) begin
                  case (op)
                     OP_NEXT: upc <= upc_inc;
                     OP_JUMP: upc <= target;
                     OP_BRZ:  upc <= z_flag ? target : upc_inc;
                     OP_BRNZ: upc <= z_flag ? upc_inc : target;
                     OP_DISP: upc <= opcode;
                     OP_CALL: begin
                        ret <= upc_inc;
                        upc <= target;
                     end
                     OP_RET:  upc <= ret;
                     OP_HALT: state <= HALT;
                     default: upc <= upc_inc;
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a bench-owned ROM array feeds cw_in
// combinationally and every cycle is checked against hand-computed values.
module tb_micro_sequencer;

   localparam int ADDR_W = 5;
   localparam int CW_W   = 37;

   localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BRZ = 3'd2, BRNZ = 3'd3,
                          DISP = 3'd4, CALL = 3'd5, RET = 3'd6, HLT = 3'd7;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              stall;
   logic              z_flag;
   logic [ADDR_W-1:0] opcode;
   logic [CW_W-1:0]   cw_in;
   logic [ADDR_W-1:0] rom_addr;
   logic [CW_W-1:0]   ctrl_out;
   logic              ctrl_valid;
   logic              halted;

   logic [CW_W-1:0]   rom [32];
   int                checks;
   int                errors;

   micro_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
      .z_flag(z_flag), .opcode(opcode), .cw_in(cw_in),
      .rom_addr(rom_addr), .ctrl_out(ctrl_out),
      .ctrl_valid(ctrl_valid), .halted(halted)
   );

   assign cw_in = rom[rom_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Payload in the upper bits makes every word distinct on ctrl_out.
   function automatic logic [CW_W-1:0] mkw(input logic [2:0] op, input logic [4:0] tgt);
      return {21'h15A5A, op, tgt, op, tgt};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   // Running cycle: address, live word and not halted.
   task automatic checkRun(input string tag, input logic [4:0] addr);
      checkOutput({tag, "_addr"}, 64'(rom_addr), 64'(addr));
      checkOutput({tag, "_valid"}, 64'(ctrl_valid), 64'd1);
      checkOutput({tag, "_out"}, 64'(ctrl_out), 64'(rom[addr]));
   endtask

   task automatic checkIdle(input string tag, input logic [4:0] addr, input logic hlt);
      checkOutput({tag, "_addr"}, 64'(rom_addr), 64'(addr));
      checkOutput({tag, "_valid"}, 64'(ctrl_valid), 64'd0);
      checkOutput({tag, "_out"}, 64'(ctrl_out), 64'd0);
      checkOutput({tag, "_halted"}, 64'(halted), 64'(hlt));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 32; i++) rom[i] = mkw(NEXT, 5'd0);
      start = 0; stall = 0; z_flag = 0; opcode = '0;
      rst_n = 0;
      #12;
      checkIdle("reset", 5'd0, 1'b0);

      // NEXT then JUMP 5; start while running is ignored
      rom[1] = mkw(JUMP, 5'd5);
      rst_n = 1;
      applyStimulus();
      checkIdle("idle_no_start", 5'd0, 1'b0);
      start = 1;
      applyStimulus();
      start = 0;
      checkRun("run0", 5'd0);
      applyStimulus();
      checkRun("run1", 5'd1);
      applyStimulus();
      checkRun("jump5", 5'd5);
      rom[6] = mkw(JUMP, 5'd10);
      start = 1;
      applyStimulus();
      start = 0;
      checkRun("start_ignored", 5'd6);

      // BRNZ / BRZ with both flag values
      rom[10] = mkw(BRNZ, 5'd13);
      rom[13] = mkw(JUMP, 5'd10);
      rom[11] = mkw(JUMP, 5'd10);
      applyStimulus();
      checkRun("at10", 5'd10);
      z_flag = 0;
      applyStimulus();
      checkRun("brnz_z0", 5'd13);
      applyStimulus();
      z_flag = 1;
      applyStimulus();
      checkRun("brnz_z1", 5'd11);
      applyStimulus();
      rom[10] = mkw(BRZ, 5'd13);
      applyStimulus();
      checkRun("brz_z1", 5'd13);
      applyStimulus();
      z_flag = 0;
      applyStimulus();
      checkRun("brz_z0", 5'd11);

      // Asynchronous reset mid-run, between clock edges
      #2;
      rst_n = 0;
      #1;
      checkIdle("async_rst", 5'd0, 1'b0);
      #3;
      rst_n = 1;

      // Dispatch, stall, wrap
      rom[0]  = mkw(DISP, 5'd0);
      rom[20] = mkw(NEXT, 5'd0);
      rom[21] = mkw(JUMP, 5'd31);
      rom[31] = mkw(NEXT, 5'd0);
      opcode = 5'd20;
      start = 1;
      applyStimulus();
      start = 0;
      checkRun("disp_at0", 5'd0);
      applyStimulus();
      checkRun("disp20", 5'd20);
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         opcode = 5'd3;
         applyStimulus();
         checkIdle("stall", 5'd20, 1'b0);
      end
      stall = 0;
      #1;
      checkRun("unstall", 5'd20);
      applyStimulus();
      checkRun("after_stall", 5'd21);
      applyStimulus();
      checkRun("at31", 5'd31);
      opcode = 5'd20;
      rom[0] = mkw(JUMP, 5'd4);
      applyStimulus();
      checkRun("wrap0", 5'd0);

      // CALL / RET, then HALT at 26
      rom[4]  = mkw(CALL, 5'd23);
      rom[23] = mkw(RET, 5'd0);
      rom[5]  = mkw(JUMP, 5'd26);
      rom[26] = mkw(HLT, 5'd0);
      applyStimulus();
      checkRun("at4", 5'd4);
      applyStimulus();
      checkRun("call23", 5'd23);
      applyStimulus();
      checkRun("ret5", 5'd5);
      applyStimulus();
      checkRun("halt_word", 5'd26);
      checkOutput("halt_word_halted", 64'(halted), 64'd0);
      applyStimulus();
      checkIdle("halted1", 5'd26, 1'b1);
      applyStimulus();
      checkIdle("halted2", 5'd26, 1'b1);

      // start together with stall from HALT
      start = 1;
      stall = 1;
      applyStimulus();
      start = 0;
      checkIdle("restart_stalled", 5'd0, 1'b0);
      stall = 0;
      #1;
      checkRun("restart_run", 5'd0);
      applyStimulus();
      checkRun("restart_next", 5'd4);

      // RET straight after reset returns to FETCH_ADDR
      rst_n = 0;
      #2;
      rst_n = 1;
      rom[0] = mkw(JUMP, 5'd7);
      rom[7] = mkw(RET, 5'd0);
      start = 1;
      applyStimulus();
      start = 0;
      checkRun("ret_rst_at0", 5'd0);
      applyStimulus();
      checkRun("ret_rst_at7", 5'd7);
      applyStimulus();
      checkRun("ret_rst_fetch", 5'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
